// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset CPU: fetch FSM states, PC step and
// jump-target field layout.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        EXEC  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam logic [5:0] OPC_J   = 6'h02;
    localparam logic [5:0] OPC_JAL = 6'h03;

    localparam int J_TGT_MSB = 25;
    localparam int J_TGT_LSB = 0;

    // j/jal target: keep the 256 MB region of the following instruction.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus_4,
                                                input logic [25:0] tgt);
        return {pc_plus_4[31:28], tgt, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux (jr > j/jal > taken branch > fall-through) with
// alignment and ROM-range fault detection.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic [31:0] pc_plus_4_i,
    input  logic [25:0] jtarget_i,
    input  logic [31:0] addr_result_i,
    input  logic [31:0] read_data_1_i,
    input  logic        zero_i,
    input  logic        branch_i,
    input  logic        nbranch_i,
    input  logic        jmp_i,
    input  logic        jal_i,
    input  logic        jr_i,
    output logic [31:0] next_pc_o,
    output logic        fault_o
);

    logic taken;

    always_comb begin
        taken     = (branch_i & zero_i) | (nbranch_i & ~zero_i);
        next_pc_o = pc_plus_4_i;
        if (jr_i) begin
            next_pc_o = read_data_1_i;
        end else if (jmp_i | jal_i) begin
            next_pc_o = jump_target(pc_plus_4_i, jtarget_i);
        end else if (taken) begin
            next_pc_o = addr_result_i;
        end
        // Anything at or above the ROM size, including fall-through off the end.
        fault_o = (next_pc_o[1:0] != 2'b00) || ((next_pc_o >> (ADDR_W + 2)) != 32'd0);
    end

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction fetch / PC sequencing: requests a word from the multi-cycle ROM,
// holds it for the execute commit window, then advances the PC.
module ifetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       Instruction,
    output logic [31:0]       PC_plus_4,
    output logic              exec_valid,
    input  logic              stall,
    input  logic [31:0]       Addr_Result,
    input  logic              Zero,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jr,
    input  logic [31:0]       Read_data_1,
    output logic              pc_err,
    output logic [31:0]       instr_count,
    output state_t            state_dbg
);

    // Handshake: in REQ, imem_req=1 with imem_addr held; the word is taken on
    // the first rising edge where imem_ready=1. imem_ready is ignored elsewhere.

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        imem_req_q;
    logic        exec_valid_q;
    logic        pc_err_q;

    logic [31:0] next_pc;
    logic        fault;

    assign PC_plus_4   = pc_q + PC_STEP;
    assign imem_addr   = pc_q[ADDR_W+1:2];
    assign imem_req    = imem_req_q;
    assign exec_valid  = exec_valid_q;
    assign pc_err      = pc_err_q;
    assign Instruction = instr_q;
    assign instr_count = count_q;
    assign state_dbg   = state_q;

    next_pc_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_sel (
        .pc_plus_4_i   (PC_plus_4),
        .jtarget_i     (instr_q[J_TGT_MSB:J_TGT_LSB]),
        .addr_result_i (Addr_Result),
        .read_data_1_i (Read_data_1),
        .zero_i        (Zero),
        .branch_i      (Branch),
        .nbranch_i     (nBranch),
        .jmp_i         (Jmp),
        .jal_i         (Jal),
        .jr_i          (Jr),
        .next_pc_o     (next_pc),
        .fault_o       (fault)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            count_q      <= 32'd0;
            imem_req_q   <= 1'b0;
            exec_valid_q <= 1'b0;
            pc_err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= REQ;
                    imem_req_q <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr_q      <= imem_rdata;
                        state_q      <= EXEC;
                        imem_req_q   <= 1'b0;
                        exec_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        // A faulting instruction still retires; only the PC update is refused.
                        count_q      <= count_q + 32'd1;
                        exec_valid_q <= 1'b0;
                        if (fault) begin
                            state_q  <= ERROR;
                            pc_err_q <= 1'b1;
                        end else begin
                            pc_q       <= next_pc;
                            state_q    <= REQ;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                ERROR: begin
                    imem_req_q   <= 1'b0;
                    exec_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    imem_req_q   <= 1'b0;
                    exec_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: reset, ROM wait states, next-PC selection table,
// stall, faults, mid-fetch reset and a randomized run against a reference model.
module tb_ifetch_sequencer;
    import cpu_pkg::*;

    localparam int          ADDR_W   = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic        br, nbr, jmp, jal, jr, zero;
        logic [31:0] ar, rd1;
    } ctrl_t;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] iw;
        ctrl_t       c;
        logic [31:0] nxt;
        logic        err;
    } vec_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready = 1'b0;
    logic [31:0]       imem_rdata = 32'd0;
    logic [31:0]       Instruction;
    logic [31:0]       PC_plus_4;
    logic              exec_valid;
    logic              stall = 1'b0;
    logic [31:0]       Addr_Result = 32'd0;
    logic              Zero = 1'b0;
    logic              Branch = 1'b0;
    logic              nBranch = 1'b0;
    logic              Jmp = 1'b0;
    logic              Jal = 1'b0;
    logic              Jr = 1'b0;
    logic [31:0]       Read_data_1 = 32'd0;
    logic              pc_err;
    logic [31:0]       instr_count;
    state_t            state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic        exp_err;

    ifetch_sequencer #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .PC_plus_4   (PC_plus_4),
        .exec_valid  (exec_valid),
        .stall       (stall),
        .Addr_Result (Addr_Result),
        .Zero        (Zero),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .Read_data_1 (Read_data_1),
        .pc_err      (pc_err),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ctrl_t mk_ctrl(input logic br, nbr, jmp, jal, jr, zero,
                                      input logic [31:0] ar, rd1);
        ctrl_t c;
        c.br = br; c.nbr = nbr; c.jmp = jmp; c.jal = jal; c.jr = jr; c.zero = zero;
        c.ar = ar; c.rd1 = rd1;
        return c;
    endfunction

    // Reference: next PC from the architectural rules, plus whether it is legal.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] iw,
                                             input ctrl_t c);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (c.jr) return c.rd1;
        if (c.jmp || c.jal) return (seq & 32'hF000_0000) + ((iw % 32'h0400_0000) * 4);
        if ((c.br && c.zero) || (c.nbr && !c.zero)) return c.ar;
        return seq;
    endfunction

    function automatic logic ref_fault(input logic [31:0] nxt);
        return (nxt % 4 != 0) || (nxt >= (32'd1 << (ADDR_W + 2)));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_ctrl(input ctrl_t c);
        Branch = c.br; nBranch = c.nbr; Jmp = c.jmp; Jal = c.jal; Jr = c.jr;
        Zero = c.zero; Addr_Result = c.ar; Read_data_1 = c.rd1;
    endtask

    task automatic do_reset();
        stall = 1'b0; imem_ready = 1'b0;
        drive_ctrl(mk_ctrl(0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_exec_valid", exec_valid, 0);
        chk("rst_pc_err", pc_err, 0);
        chk("rst_instr_count", instr_count, 0);
        chk("rst_instruction", Instruction, 0);
        chk("rst_pc_plus_4", PC_plus_4, RESET_PC + 32'd4);
        chk("rst_state", state_dbg, IDLE);
        reset_n = 1'b1;
        exp_pc = RESET_PC; exp_cnt = 0; exp_err = 0;
    endtask

    // One fetch/execute: serve the ROM after `waits` cycles, hold the commit
    // window for `stalls` extra cycles, then check the PC update.
    task automatic run_instr(input logic [31:0] iw, input int waits, input int stalls,
                             input ctrl_t c, input logic [31:0] nxt, input logic err);
        int k;
        k = 0;
        while (!imem_req && k < 4) begin
            @(negedge clock);
            k++;
        end
        chk("req_seen", imem_req, 1);
        if (!imem_req) return;
        chk("req_addr", imem_addr, exp_pc[ADDR_W+1:2]);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            @(negedge clock);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, exp_pc[ADDR_W+1:2]);
            chk("wait_exec_valid", exec_valid, 0);
        end
        imem_ready = 1'b1;
        imem_rdata = iw;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("exec_valid", exec_valid, 1);
        chk("exec_instruction", Instruction, iw);
        chk("exec_pc_plus_4", PC_plus_4, exp_pc + 32'd4);
        chk("exec_req_low", imem_req, 0);
        drive_ctrl(c);
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            imem_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            chk("stall_exec_valid", exec_valid, 1);
            chk("stall_count", instr_count, exp_cnt);
            chk("stall_pc_plus_4", PC_plus_4, exp_pc + 32'd4);
            chk("stall_instruction", Instruction, iw);
        end
        stall = 1'b0;
        @(negedge clock);
        imem_ready = 1'b0;
        drive_ctrl(mk_ctrl(0, 0, 0, 0, 0, 0, 32'd0, 32'd0));
        exp_cnt = exp_cnt + 1;
        if (err) exp_err = 1'b1;
        else exp_pc = nxt;
        chk("retire_count", instr_count, exp_cnt);
        chk("retire_pc_err", pc_err, exp_err);
        chk("retire_exec_valid", exec_valid, 0);
        chk("retire_pc_plus_4", PC_plus_4, exp_pc + 32'd4);
        chk("retire_req", imem_req, !exp_err);
        if (!exp_err) chk("retire_addr", imem_addr, exp_pc[ADDR_W+1:2]);
        else begin
            for (int i = 0; i < 3; i++) begin
                imem_ready = 1'b1;
                @(negedge clock);
                chk("err_req", imem_req, 0);
                chk("err_exec_valid", exec_valid, 0);
                chk("err_sticky", pc_err, 1);
                chk("err_pc_held", PC_plus_4, exp_pc + 32'd4);
            end
            imem_ready = 1'b0;
        end
    endtask

    task automatic run_model(input logic [31:0] iw, input int waits, input int stalls,
                             input ctrl_t c);
        logic [31:0] nxt;
        nxt = ref_next(exp_pc, iw, c);
        run_instr(iw, waits, stalls, c, nxt, ref_fault(nxt));
    endtask

    // ---------------- test ----------------
    vec_t vecs[13];
    ctrl_t none;

    initial begin
        int t0;
        none = mk_ctrl(0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
        //              name        start pc      instr          br nb j jl jr z  Addr_Result   Read_data_1      next          err
        vecs[0]  = '{"beq_taken",   32'h0,     32'h1000_0000, mk_ctrl(1, 0, 0, 0, 0, 1, 32'h40, 32'h0),    32'h40,    1'b0};
        vecs[1]  = '{"beq_not",     32'h0,     32'h1000_0000, mk_ctrl(1, 0, 0, 0, 0, 0, 32'h40, 32'h0),    32'h4,     1'b0};
        vecs[2]  = '{"bne_taken",   32'h0,     32'h1400_0000, mk_ctrl(0, 1, 0, 0, 0, 0, 32'h40, 32'h0),    32'h40,    1'b0};
        vecs[3]  = '{"bne_not",     32'h0,     32'h1400_0000, mk_ctrl(0, 1, 0, 0, 0, 1, 32'h40, 32'h0),    32'h4,     1'b0};
        vecs[4]  = '{"jr_over_beq", 32'h0,     32'h0000_0008, mk_ctrl(1, 0, 0, 0, 1, 1, 32'h40, 32'h100),  32'h100,   1'b0};
        vecs[5]  = '{"jal",         32'h8,     32'h0C00_0020, mk_ctrl(0, 0, 0, 1, 0, 0, 32'h0, 32'h0),     32'h80,    1'b0};
        vecs[6]  = '{"j",           32'h1000,  32'h0800_0010, mk_ctrl(0, 0, 1, 0, 0, 0, 32'h0, 32'h0),     32'h40,    1'b0};
        vecs[7]  = '{"j_over_beq",  32'h20,    32'h0800_0100, mk_ctrl(1, 0, 1, 0, 0, 1, 32'h40, 32'h0),    32'h400,   1'b0};
        vecs[8]  = '{"beq_bne",     32'h10,    32'h1000_0000, mk_ctrl(1, 1, 0, 0, 0, 0, 32'h80, 32'h0),    32'h80,    1'b0};
        vecs[9]  = '{"jr_misalign", 32'h0,     32'h0000_0008, mk_ctrl(0, 0, 0, 0, 1, 0, 32'h0, 32'h102),   32'h102,   1'b1};
        vecs[10] = '{"jr_range",    32'h0,     32'h0000_0008, mk_ctrl(0, 0, 0, 0, 1, 0, 32'h0, 32'h10000), 32'h10000, 1'b1};
        vecs[11] = '{"fall_off",    32'hFFFC,  32'h0000_0000, mk_ctrl(0, 0, 0, 0, 0, 0, 32'h0, 32'h0),     32'h10000, 1'b1};
        vecs[12] = '{"br_misalign", 32'h0,     32'h1000_0000, mk_ctrl(1, 0, 0, 0, 0, 1, 32'h41, 32'h0),    32'h41,    1'b1};

        // Reset release with a 3-wait ROM, then sequential fall-through.
        do_reset();
        run_instr(32'h0000_0020, 3, 0, none, 32'h4, 1'b0);
        chk("seq_addr_1", imem_addr, 1);

        // Zero-wait throughput: 5 retires in 10 cycles from the first REQ.
        do_reset();
        begin
            int k;
            k = 0;
            while (!imem_req && k < 4) begin
                @(negedge clock);
                k++;
            end
        end
        t0 = cyc;
        for (int i = 0; i < 5; i++) run_model(32'h0000_0000, 0, 0, none);
        chk("tput_cycles", cyc - t0, 10);
        chk("tput_count", instr_count, 5);

        // Table of next-PC selections, each from a PC set up by a jr.
        foreach (vecs[i]) begin
            do_reset();
            run_instr(32'h0, $urandom_range(0, 2), 0,
                      mk_ctrl(0, 0, 0, 0, 1, 0, 32'h0, vecs[i].pc), vecs[i].pc, 1'b0);
            run_instr(vecs[i].iw, $urandom_range(0, 2), 0, vecs[i].c, vecs[i].nxt, vecs[i].err);
        end

        // Reset out of ERROR clears the sticky flag.
        do_reset();

        // Long stall: commit window of 6 cycles, nothing retires early.
        run_instr(32'h0, 1, 5, none, 32'h4, 1'b0);

        // Reset asserted in the middle of a REQ drops imem_req without a clock edge.
        run_instr(32'h0, 0, 0, mk_ctrl(0, 0, 0, 0, 1, 0, 32'h0, 32'h200), 32'h200, 1'b0);
        chk("mid_req_pre", imem_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_req_drop", imem_req, 0);
        chk("mid_req_pc", PC_plus_4, RESET_PC + 32'd4);
        chk("mid_req_count", instr_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_pc = RESET_PC; exp_cnt = 0; exp_err = 0;

        // Randomized run against the reference model.
        do_reset();
        for (int n = 0; n < 60; n++) begin
            ctrl_t c;
            logic [31:0] iw;
            int kind;
            c = none;
            iw = {$urandom_range(0, 63), 12'd0, 14'($urandom_range(0, 16383))};
            if ($urandom_range(0, 9) == 0) iw = $urandom;
            kind = $urandom_range(0, 6);
            c.zero = 1'($urandom_range(0, 1));
            c.ar  = {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
            c.rd1 = {16'd0, 14'($urandom_range(0, 16383)), 2'b00};
            if ($urandom_range(0, 7) == 0) c.ar = $urandom;
            if ($urandom_range(0, 7) == 0) c.rd1 = $urandom;
            case (kind)
                1: c.br  = 1'b1;
                2: c.nbr = 1'b1;
                3: c.jmp = 1'b1;
                4: c.jal = 1'b1;
                5: c.jr  = 1'b1;
                6: begin
                    c.br = 1'($urandom_range(0, 1)); c.nbr = 1'($urandom_range(0, 1));
                    c.jmp = 1'($urandom_range(0, 1)); c.jr = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            run_model(iw, $urandom_range(0, 3), $urandom_range(0, 2), c);
            if (exp_err) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
